// File: rtl/signed_pow2_divider_pipe.sv
// signed_pow2_divider_pipe
// Divides a two's-complement dividend by 2^S using a valid/ready pipeline.
// Stage 0 adds the truncation bias and stages 1..SW each apply one binary
// weight of the right shift. Optional macro SIGNED_POW2_DIVIDER_INEXACT_EN adds a
// down_inexact flag that reports whether any nonzero dividend bit was dropped.
// N must be a power of two and at least 4.
module signed_pow2_divider_pipe #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [N-1:0]         up_data,
  input  logic [$clog2(N)-1:0] up_shift,
  input  logic                 up_mode,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [N-1:0]         down_data
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
  ,
  output logic                 down_inexact
`endif
);

  localparam int SW = $clog2(N);

  // Per-stage state: stage 0 holds the biased operand, stage k has applied
  // shift bits 0..k-1. The shift amount travels only as far as it is needed.
  logic [SW:0]   valid_q;
  logic [N-1:0]  data_q  [0:SW];
  logic [SW-1:0] shift_q [0:SW-1];
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
  logic [SW:0]   inexact_q;
`endif

  logic [SW:0]   adv;         // stage k hands its contents downstream this cycle
  logic          accept;
  logic [N-1:0]  bias_mask;   // 2^S - 1, also the set of bits the shift drops
  logic [N-1:0]  stage0_d;
  logic [N-1:0]  shifted [1:SW];

  // Walk from the output back to the input: a stage may advance when it is
  // full and the stage after it is empty or advancing itself.
  always_comb begin
    logic free;
    adv  = '0;
    free = down_ready;
    for (int k = SW; k >= 0; k--) begin
      adv[k] = valid_q[k] & free;
      free   = ~valid_q[k] | adv[k];
    end
    up_ready = free;
  end

  // Bias for round-toward-zero: only negative operands in truncate mode.
  // A negative value plus at most 2^(N-1)-1 always stays in range.
  always_comb begin
    bias_mask = ~({N{1'b1}} << up_shift);
    stage0_d  = up_data + ((up_mode & up_data[N-1]) ? bias_mask : '0);
    accept    = up_valid & up_ready;
  end

  // Stage gi shifts by 2^(gi-1) when its shift bit is set, replicating the sign.
  generate
    for (genvar gi = 1; gi <= SW; gi++) begin : g_shift
      localparam int AMT = 1 << (gi - 1);
      assign shifted[gi] = shift_q[gi-1][gi-1]
                           ? {{AMT{data_q[gi-1][N-1]}}, data_q[gi-1][N-1:AMT]}
                           : data_q[gi-1];
    end
  endgenerate

  // Pipeline registers: a stage loads whenever its predecessor advances and
  // empties when it advances with nothing arriving behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k <= SW; k++) data_q[k] <= '0;
      for (int k = 0; k < SW; k++) shift_q[k] <= '0;
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
      inexact_q <= '0;
`endif
    end else begin
      if (accept) begin
        valid_q[0] <= 1'b1;
        data_q[0]  <= stage0_d;
        shift_q[0] <= up_shift;
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
        inexact_q[0] <= |(up_data & bias_mask);
`endif
      end else if (adv[0]) begin
        valid_q[0] <= 1'b0;
      end
      for (int k = 1; k <= SW; k++) begin
        if (adv[k-1]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= shifted[k];
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
          inexact_q[k] <= inexact_q[k-1];
`endif
        end else if (adv[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      for (int k = 1; k < SW; k++) begin
        if (adv[k-1]) shift_q[k] <= shift_q[k-1];
      end
    end
  end

  assign down_valid = valid_q[SW];
  assign down_data  = data_q[SW];
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
  assign down_inexact = inexact_q[SW];
`endif

endmodule

// File: tb/tb_signed_pow2_divider_pipe.sv
// tb_signed_pow2_divider_pipe
// Directed and streaming checks for signed_pow2_divider_pipe at N=8.
// Optional macro SIGNED_POW2_DIVIDER_INEXACT_EN enables the down_inexact checks.
module tb_signed_pow2_divider_pipe;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_valid = 1'b0;
  logic       up_ready;
  logic [7:0] up_data = '0;
  logic [2:0] up_shift = '0;
  logic       up_mode = 1'b0;
  logic       down_valid;
  logic       down_ready = 1'b0;
  logic [7:0] down_data;
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
  logic       down_inexact;
`endif

  int checks = 0;
  int errors = 0;

  signed_pow2_divider_pipe #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_shift   (up_shift),
    .up_mode    (up_mode),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
    ,
    .down_inexact (down_inexact)
`endif
  );

  always #5 clk = ~clk;

  // Reference quotient: integer division truncates toward zero; floor mode
  // steps negative inexact quotients down by one.
  function automatic logic [7:0] ref_q(input logic [7:0] d, input int s, input logic m);
    int a, p, q;
    a = int'($signed(d));
    p = 1 << s;
    q = a / p;
    if (!m && a < 0 && (a % p) != 0) q = q - 1;
    return 8'(q);
  endfunction

  function automatic logic ref_inx(input logic [7:0] d, input int s);
    return (int'(d) % (1 << s)) != 0;
  endfunction

  function automatic logic cur_inx();
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
    return down_inexact;
`else
    return 1'b0;
`endif
  endfunction

  // Sends one operand into an empty pipeline and waits for its result.
  // lat is the number of cycles from acceptance to down_valid, -1 on timeout.
  task automatic xfer(input logic [7:0] d, input logic [2:0] s, input logic m,
                      output logic [7:0] res, output logic inx, output int lat);
    bit acc;
    lat = -1; res = '0; inx = 1'b0; acc = 1'b0;
    @(negedge clk);
    up_valid = 1'b1; up_data = d; up_shift = s; up_mode = m; down_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (up_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    if (!acc) begin up_valid = 1'b0; return; end
    @(negedge clk);
    up_valid = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      #1;
      if (down_valid) begin res = down_data; inx = cur_inx(); lat = t; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (down_valid !== 1'b0) begin errors++; $display("FAIL reset_down_valid got %b expected 0", down_valid); end
    checks++;
    if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_up_ready got %b expected 1", up_ready); end
    checks++;
    if (down_data !== 8'h00) begin errors++; $display("FAIL reset_down_data got %h expected 00", down_data); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (down_valid !== 1'b0 || up_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle got valid=%b ready=%b expected valid=0 ready=1", down_valid, up_ready);
    end
  endtask

  task automatic test_floor_trunc();
    logic [7:0] r; logic x; int lat;
    xfer(8'hF9, 3'd1, 1'b0, r, x, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL floor_latency got %0d expected 4", lat); end
    checks++;
    if (r !== 8'hFC) begin errors++; $display("FAIL floor_F9_s1 got %h expected FC", r); end
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
    checks++;
    if (x !== 1'b1) begin errors++; $display("FAIL floor_F9_s1_inexact got %b expected 1", x); end
`endif
    xfer(8'hF9, 3'd1, 1'b1, r, x, lat);
    checks++;
    if (r !== 8'hFD || lat !== 4) begin errors++; $display("FAIL trunc_F9_s1 got %h lat %0d expected FD lat 4", r, lat); end
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
    checks++;
    if (x !== 1'b1) begin errors++; $display("FAIL trunc_F9_s1_inexact got %b expected 1", x); end
`endif
    // S=0 passes the operand through unchanged in both modes
    xfer(8'hB3, 3'd0, 1'b1, r, x, lat);
    checks++;
    if (r !== 8'hB3) begin errors++; $display("FAIL s0_trunc got %h expected B3", r); end
    xfer(8'hB3, 3'd0, 1'b0, r, x, lat);
    checks++;
    if (r !== 8'hB3) begin errors++; $display("FAIL s0_floor got %h expected B3", r); end
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
    checks++;
    if (x !== 1'b0) begin errors++; $display("FAIL s0_inexact got %b expected 0", x); end
`endif
    // Non-negative operands agree across modes: 0x3D >> 2 = 0x0F
    xfer(8'h3D, 3'd2, 1'b1, r, x, lat);
    checks++;
    if (r !== 8'h0F) begin errors++; $display("FAIL nonneg_trunc got %h expected 0F", r); end
    xfer(8'h3D, 3'd2, 1'b0, r, x, lat);
    checks++;
    if (r !== 8'h0F) begin errors++; $display("FAIL nonneg_floor got %h expected 0F", r); end
  endtask

  task automatic test_extremes();
    logic [7:0] r; logic x; int lat;
    xfer(8'h80, 3'd7, 1'b0, r, x, lat);
    checks++;
    if (r !== 8'hFF) begin errors++; $display("FAIL min_s7_floor got %h expected FF", r); end
    xfer(8'h80, 3'd7, 1'b1, r, x, lat);
    checks++;
    if (r !== 8'hFF) begin errors++; $display("FAIL min_s7_trunc got %h expected FF", r); end
    xfer(8'h64, 3'd3, 1'b0, r, x, lat);
    checks++;
    if (r !== 8'h0C) begin errors++; $display("FAIL d100_s3 got %h expected 0C", r); end
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
    checks++;
    if (x !== 1'b1) begin errors++; $display("FAIL d100_s3_inexact got %b expected 1", x); end
`endif
    xfer(8'h60, 3'd5, 1'b1, r, x, lat);
    checks++;
    if (r !== 8'h03) begin errors++; $display("FAIL d96_s5 got %h expected 03", r); end
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
    checks++;
    if (x !== 1'b0) begin errors++; $display("FAIL d96_s5_inexact got %b expected 0", x); end
`endif
    // -1 truncated by 128 rounds to zero, floored stays -1
    xfer(8'hFF, 3'd7, 1'b1, r, x, lat);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL m1_s7_trunc got %h expected 00", r); end
  endtask

  task automatic test_stream();
    logic [8:0] exp_q[$];
    logic [8:0] e;
    int cyc = 0, sent = 0, got = 0, first_acc = -1, first_del = -1, last_del = -1;
    down_ready = 1'b1;
    while (got < 16 && cyc < 200) begin
      @(negedge clk);
      if (sent < 16) begin
        up_valid = 1'b1;
        up_data  = 8'($urandom);
        up_shift = 3'($urandom_range(0, 7));
        up_mode  = 1'($urandom_range(0, 1));
      end else begin
        up_valid = 1'b0;
      end
      #1;
      if (down_valid && down_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra got %h expected no result", down_data);
        end else begin
          e = exp_q.pop_front();
          if (down_data !== e[7:0] || cur_inx() !== e[8]) begin
            errors++; $display("FAIL stream[%0d] got %h/%b expected %h/%b", got, down_data, cur_inx(), e[7:0], e[8]);
          end
        end
        if (first_del < 0) first_del = cyc;
        else begin
          checks++;
          if (cyc != last_del + 1) begin errors++; $display("FAIL stream_gap[%0d] got cycle %0d expected %0d", got, cyc, last_del + 1); end
        end
        last_del = cyc;
        got++;
      end
      if (up_valid && up_ready) begin
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
        exp_q.push_back({ref_inx(up_data, int'(up_shift)), ref_q(up_data, int'(up_shift), up_mode)});
`else
        exp_q.push_back({1'b0, ref_q(up_data, int'(up_shift), up_mode)});
`endif
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      cyc++;
    end
    up_valid = 1'b0;
    checks++;
    if (got != 16) begin errors++; $display("FAIL stream_count got %0d expected 16", got); end
    checks++;
    if (first_del - first_acc != 4) begin errors++; $display("FAIL stream_latency got %0d expected 4", first_del - first_acc); end
    checks++;
    if (sent != 16 || last_del - first_acc != 19) begin
      errors++; $display("FAIL stream_throughput got span %0d sent %0d expected 19 and 16", last_del - first_acc, sent);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bd [6] = '{8'hF9, 8'h64, 8'h80, 8'h7F, 8'h01, 8'hC3};
    logic [2:0] bs [6] = '{3'd1, 3'd3, 3'd7, 3'd2, 3'd0, 3'd5};
    logic       bm [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp_q[$];
    logic [7:0] held = '0, e;
    bit have_held = 1'b0;
    logic last_ready = 1'b1;
    int idx = 0, got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      down_ready = 1'b0;
      up_valid = (idx < 6);
      if (idx < 6) begin up_data = bd[idx]; up_shift = bs[idx]; up_mode = bm[idx]; end
      #1;
      if (down_valid) begin
        if (!have_held) begin held = down_data; have_held = 1'b1; end
        else begin
          checks++;
          if (down_data !== held) begin errors++; $display("FAIL bp_stable[%0d] got %h expected %h", c, down_data, held); end
        end
      end
      last_ready = up_ready;
      if (up_valid && up_ready) begin exp_q.push_back(ref_q(bd[idx], int'(bs[idx]), bm[idx])); idx++; end
    end
    checks++;
    if (idx != 4) begin errors++; $display("FAIL bp_accepted got %0d expected 4", idx); end
    checks++;
    if (last_ready !== 1'b0) begin errors++; $display("FAIL bp_up_ready got %b expected 0", last_ready); end
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(negedge clk);
      down_ready = 1'b1;
      up_valid = (idx < 6);
      if (idx < 6) begin up_data = bd[idx]; up_shift = bs[idx]; up_mode = bm[idx]; end
      #1;
      if (down_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra got %h expected no result", down_data); end
        else begin
          e = exp_q.pop_front();
          if (down_data !== e) begin errors++; $display("FAIL bp_drain[%0d] got %h expected %h", got, down_data, e); end
        end
        got++;
      end
      if (up_valid && up_ready) begin exp_q.push_back(ref_q(bd[idx], int'(bs[idx]), bm[idx])); idx++; end
    end
    up_valid = 1'b0;
    checks++;
    if (got != 6) begin errors++; $display("FAIL bp_drain_count got %0d expected 6", got); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int stale = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      down_ready = 1'b0; up_valid = 1'b1;
      up_data = 8'(8'h90 + c); up_shift = 3'd2; up_mode = 1'b1;
    end
    @(negedge clk);
    up_valid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      #1;
      if (down_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rmid_prefill got down_valid=0 expected 1"); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (down_valid !== 1'b0 || up_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_async got valid=%b ready=%b expected valid=0 ready=1", down_valid, up_ready);
    end
    checks++;
    if (down_data !== 8'h00) begin errors++; $display("FAIL rmid_data got %h expected 00", down_data); end
    @(negedge clk);
    rst_n = 1'b1;
    down_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (down_valid) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL rmid_stale got %0d results expected 0", stale); end
  endtask

  task automatic test_exhaustive();
    logic [8:0] exp_q[$];
    logic [8:0] e;
    int idx = 0, got = 0, bad = 0;
    for (int c = 0; c < 20000 && got < 4096; c++) begin
      @(negedge clk);
      down_ready = 1'($urandom_range(0, 1));
      up_valid = (idx < 4096);
      if (idx < 4096) begin
        up_data = 8'(idx); up_shift = 3'(idx >> 8); up_mode = 1'(idx >> 11);
      end
      #1;
      if (down_valid && down_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; bad++; $display("FAIL exh_extra got %h expected no result", down_data); end
        else begin
          e = exp_q.pop_front();
          if (down_data !== e[7:0] || cur_inx() !== e[8]) begin
            errors++; bad++;
            $display("FAIL exh[%0d] got %h/%b expected %h/%b", got, down_data, cur_inx(), e[7:0], e[8]);
          end
        end
        got++;
      end
      if (up_valid && up_ready) begin
`ifdef SIGNED_POW2_DIVIDER_INEXACT_EN
        exp_q.push_back({ref_inx(up_data, int'(up_shift)), ref_q(up_data, int'(up_shift), up_mode)});
`else
        exp_q.push_back({1'b0, ref_q(up_data, int'(up_shift), up_mode)});
`endif
        idx++;
      end
    end
    up_valid = 1'b0;
    checks++;
    if (got != 4096) begin errors++; $display("FAIL exh_count got %0d expected 4096", got); end
    $display("exhaustive: %0d results, %0d bad", got, bad);
  endtask

  initial begin
    test_reset();
    test_floor_trunc();
    test_extremes();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
